// File: rtl/edge_pulse_io.sv
`default_nettype none
// ============================================================================
// Module   : edge_pulse_io
// Brief    : Multi-channel pad input conditioner for the 1-Wire I/O path.
//            Each channel has a synchroniser, a stable-count glitch filter,
//            and a one-clock edge pulse with per-channel edge select.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module edge_pulse_io #(
  parameter int   WIDTH       = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CNT    = 0,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [WIDTH-1:0]   i,
  input  logic [2*WIDTH-1:0] mode,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   q,
  output logic               q_any
);

  // The counter only has to reach FILT_CNT-1, but it is never narrower
  // than one bit. This keeps the FILT_CNT = 0/1 (no filtering) case legal.
  localparam int                 c_cnt_w_raw = $clog2(FILT_CNT + 1);
  localparam int                 c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;
  localparam bit                 c_no_filt   = (FILT_CNT <= 1);
  localparam int                 c_last_i    = c_no_filt ? 0 : FILT_CNT - 1;
  localparam int                 c_one_i     = 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_last_i[c_cnt_w-1:0];
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_one_i[c_cnt_w-1:0];

  generate
    for (genvar n = 0; n < WIDTH; n++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_cnt_w-1:0]     r_cnt;
      logic                   r_level;
      logic                   r_q;
      logic                   w_s;
      logic                   w_diff;
      logic                   w_accept;
      logic                   w_pulse;

      assign w_s    = r_sync[SYNC_STAGES-1];
      assign w_diff = w_s ^ r_level;
      // The update edge: a differing sample that has persisted long enough.
      assign w_accept = w_diff & (c_no_filt | (r_cnt == c_cnt_last));
      // mode is looked at only here, so changing it cannot create or
      // stretch a pulse.
      assign w_pulse = w_accept & ((w_s & mode[2*n]) | (~w_s & mode[2*n+1]));

      // Plain flop chain into the clock domain. No logic sits between stages.
      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], i[n]};
        end
      end

      // Stable-count filter. Any sample matching the current level restarts
      // the count. On acceptance the count is cleared, so it never wraps.
      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          r_level <= INIT_LEVEL;
          r_cnt   <= '0;
        end else if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_level <= w_s;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end

      // Registered one-cycle edge pulse.
      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          r_q <= 1'b0;
        end else begin
          r_q <= w_pulse;
        end
      end

      assign level[n] = r_level;
      assign q[n]     = r_q;
    end : g_chan
  endgenerate

  assign q_any = |q;

endmodule : edge_pulse_io
`default_nettype wire

// File: tb/tb_edge_pulse_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_pulse_io
// Brief    : Directed bench for edge_pulse_io. It uses three configurations:
//            a default single channel, a filtered single channel and a
//            four-channel build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_pulse_io;

  localparam logic [7:0] c_mode_c = 8'b01_10_11_00;

  logic clk;
  logic nRst;

  // Instance a: default parameters.
  logic       a_i, a_level, a_q, a_any;
  logic [1:0] a_mode;
  // Instance b: FILT_CNT = 4.
  logic       b_i, b_level, b_q, b_any;
  logic [1:0] b_mode;
  // Instance c: WIDTH = 4.
  logic [3:0] c_i, c_level, c_q;
  logic [7:0] c_mode;
  logic       c_any;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  typedef struct {
    logic [3:0] i;
    logic [7:0] mode;
    logic [3:0] lvl;
    logic [3:0] q;
  } vec_t;

  vec_t tbl[21];

  edge_pulse_io dut_a (
    .clk(clk), .nRst(nRst), .i(a_i), .mode(a_mode),
    .level(a_level), .q(a_q), .q_any(a_any)
  );

  edge_pulse_io #(.FILT_CNT(4)) dut_b (
    .clk(clk), .nRst(nRst), .i(b_i), .mode(b_mode),
    .level(b_level), .q(b_q), .q_any(b_any)
  );

  edge_pulse_io #(.WIDTH(4)) dut_c (
    .clk(clk), .nRst(nRst), .i(c_i), .mode(c_mode),
    .level(c_level), .q(c_q), .q_any(c_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock and tally any pulse seen on instance a or b.
  task automatic tick_a();
    tick();
    pulses += int'(a_q);
  endtask

  task automatic tick_b();
    tick();
    pulses += int'(b_q);
  endtask

  initial begin
    // The expected level and q columns were worked out by hand.
    // Default filtering gives 3 edges of latency. Mode is 01_10_11_00 for ch3..ch0.
    tbl[0]  = '{4'b0000, c_mode_c, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1111, c_mode_c, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1111, c_mode_c, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1111, c_mode_c, 4'b1111, 4'b1010};
    tbl[4]  = '{4'b1111, c_mode_c, 4'b1111, 4'b0000};
    tbl[5]  = '{4'b0000, c_mode_c, 4'b1111, 4'b0000};
    tbl[6]  = '{4'b0000, c_mode_c, 4'b1111, 4'b0000};
    tbl[7]  = '{4'b0000, c_mode_c, 4'b0000, 4'b0110};
    tbl[8]  = '{4'b0000, c_mode_c, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0011, c_mode_c, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0011, c_mode_c, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0011, c_mode_c, 4'b0011, 4'b0010};
    tbl[12] = '{4'b0011, 8'hFF,    4'b0011, 4'b0000};
    tbl[13] = '{4'b0011, 8'hFF,    4'b0011, 4'b0000};
    tbl[14] = '{4'b1011, 8'hFF,    4'b0011, 4'b0000};
    tbl[15] = '{4'b0011, 8'hFF,    4'b0011, 4'b0000};
    tbl[16] = '{4'b1011, 8'hFF,    4'b1011, 4'b1000};
    tbl[17] = '{4'b0011, 8'hFF,    4'b0011, 4'b1000};
    tbl[18] = '{4'b0011, 8'hFF,    4'b1011, 4'b1000};
    tbl[19] = '{4'b0011, 8'hFF,    4'b0011, 4'b1000};
    tbl[20] = '{4'b0011, 8'hFF,    4'b0011, 4'b0000};

    nRst   = 1'b0;
    a_i    = 1'b1;
    a_mode = 2'b10;
    b_i    = 1'b0;
    b_mode = 2'b11;
    c_i    = 4'b0000;
    c_mode = c_mode_c;

    // Reset state
    repeat (3) tick();
    check("reset_a_level", 32'(a_level), 32'd0);
    check("reset_a_q",     32'(a_q),     32'd0);
    check("reset_a_any",   32'(a_any),   32'd0);
    check("reset_b_level", 32'(b_level), 32'd0);
    check("reset_c_level", 32'(c_level), 32'd0);
    check("reset_c_q",     32'(c_q),     32'd0);
    nRst = 1'b1;

    // Test 1: input held high from release. With mode 10, the rising edge gives no pulse.
    pulses = 0;
    repeat (5) tick_a();
    check("t1_rise_from_reset_pulses", 32'(pulses), 32'd0);
    check("t1_level_high",             32'(a_level), 32'd1);
    a_i = 1'b0;
    tick(); tick();
    check("t1_level_before_edge3", 32'(a_level), 32'd1);
    check("t1_q_before_edge3",     32'(a_q),     32'd0);
    tick();
    check("t1_level_after_edge3", 32'(a_level), 32'd0);
    check("t1_q_after_edge3",     32'(a_q),     32'd1);
    check("t1_any_after_edge3",   32'(a_any),   32'd1);
    tick();
    check("t1_q_after_edge4", 32'(a_q), 32'd0);
    a_i = 1'b1;
    pulses = 0;
    repeat (6) tick_a();
    check("t1_rise_pulses", 32'(pulses), 32'd0);
    check("t1_rise_level",  32'(a_level), 32'd1);

    // Test 2: a 3-cycle glitch is rejected. Then a steady high is accepted at edge 6.
    pulses = 0;
    b_i = 1'b1;
    repeat (3) tick_b();
    b_i = 1'b0;
    repeat (8) tick_b();
    check("t2_glitch_pulses", 32'(pulses), 32'd0);
    check("t2_glitch_level",  32'(b_level), 32'd0);
    b_i = 1'b1;
    repeat (5) tick();
    check("t2_level_edge5", 32'(b_level), 32'd0);
    check("t2_q_edge5",     32'(b_q),     32'd0);
    tick();
    check("t2_level_edge6", 32'(b_level), 32'd1);
    check("t2_q_edge6",     32'(b_q),     32'd1);
    check("t2_any_edge6",   32'(b_any),   32'd1);
    tick();
    check("t2_q_edge7", 32'(b_q), 32'd0);
    pulses = 0;
    repeat (3) tick_b();
    check("t2_hold_pulses", 32'(pulses), 32'd0);

    // Test 3: pattern high x3, low x1, high. The count restarts, so acceptance comes 6 edges after the re-rise.
    b_i = 1'b0;
    repeat (10) tick();
    check("t3_start_level", 32'(b_level), 32'd0);
    pulses = 0;
    b_i = 1'b1;
    repeat (3) tick_b();
    b_i = 1'b0;
    tick_b();
    b_i = 1'b1;
    repeat (5) tick_b();
    check("t3_level_before_accept", 32'(b_level), 32'd0);
    tick_b();
    check("t3_level_accept", 32'(b_level), 32'd1);
    check("t3_q_accept",     32'(b_q),     32'd1);
    repeat (4) tick_b();
    check("t3_single_pulse", 32'(pulses), 32'd1);

    // Test 5: the pulse follows the mode value at the update edge.
    pulses = 0;
    b_mode = 2'b01;
    b_i = 1'b0;
    repeat (3) tick_b();
    b_mode = 2'b10;
    repeat (2) tick_b();
    check("t5_fall_level_pre", 32'(b_level), 32'd1);
    tick_b();
    check("t5_fall_level", 32'(b_level), 32'd0);
    check("t5_fall_q",     32'(b_q),     32'd1);
    tick_b();
    check("t5_fall_pulses", 32'(pulses), 32'd1);
    pulses = 0;
    b_mode = 2'b01;
    b_i = 1'b1;
    repeat (3) tick_b();
    b_mode = 2'b10;
    repeat (3) tick_b();
    check("t5_rise_level", 32'(b_level), 32'd1);
    check("t5_rise_q",     32'(b_q),     32'd0);
    for (int k = 0; k < 4; k++) begin
      b_mode = 2'(k);
      tick_b();
    end
    check("t5_stable_mode_pulses", 32'(pulses), 32'd0);
    check("t5_stable_level",       32'(b_level), 32'd1);

    // Test 4: four independent channels, driven from the table.
    for (int r = 0; r < 21; r++) begin
      c_i    = tbl[r].i;
      c_mode = tbl[r].mode;
      tick();
      check($sformatf("tbl[%0d].level", r), 32'(c_level), 32'(tbl[r].lvl));
      check($sformatf("tbl[%0d].q", r),     32'(c_q),     32'(tbl[r].q));
      check($sformatf("tbl[%0d].q_any", r), 32'(c_any),   32'(|tbl[r].q));
    end

    // Test 6: assert reset while a pulse is high. State clears at once.
    a_i = 1'b0;
    a_mode = 2'b10;
    repeat (4) tick();
    a_mode = 2'b01;
    a_i = 1'b1;
    repeat (3) tick();
    check("t6_pulse_before_reset", 32'(a_q),     32'd1);
    check("t6_level_before_reset", 32'(a_level), 32'd1);
    #2;
    nRst = 1'b0;
    #1;
    check("t6_async_q",     32'(a_q),     32'd0);
    check("t6_async_any",   32'(a_any),   32'd0);
    check("t6_async_level", 32'(a_level), 32'd0);
    check("t6_async_c_lvl", 32'(c_level), 32'd0);
    a_i = 1'b0;
    tick();
    check("t6_held_q", 32'(a_q), 32'd0);
    nRst = 1'b1;
    pulses = 0;
    repeat (20) tick_a();
    check("t6_no_pulse_after_release", 32'(pulses), 32'd0);
    check("t6_level_after_release",    32'(a_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_edge_pulse_io
`default_nettype wire
